// File: rtl/accumulate_dump_if.sv
// Sample/result bundle for accumulate_dump.
// master drives samples in; slave returns saturated frame sums.
interface accumulate_dump_if #(
  parameter int DW = 25
);
  logic                 data_i_en;
  logic signed [DW-1:0] data_i;
  logic                 data_o_en;
  logic signed [DW-1:0] data_o;
  logic                 sat_o;

  modport master (
    output data_i_en,
    output data_i,
    input  data_o_en,
    input  data_o,
    input  sat_o
  );

  modport slave (
    input  data_i_en,
    input  data_i,
    output data_o_en,
    output data_o,
    output sat_o
  );
endinterface

// File: rtl/accumulate_dump.sv
// Sums acc_num signed fixed-point samples and dumps a saturated result.
// Ports: clk, rst (async low), clr (sync frame clear), bus (slave).
module accumulate_dump #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int acc_num = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  accumulate_dump_if.slave bus
);

  localparam int DW  = width_H + width_W;
  localparam int CLG = $clog2(acc_num);
  localparam int AW  = DW + CLG + 1;
  localparam int CW  = (CLG > 0) ? CLG : 1;

  localparam logic signed [AW-1:0] MAXV =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  localparam logic [CW-1:0] LAST = CW'(acc_num - 1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 en_q, en_d;
  logic                 sat_q, sat_d;

  logic signed [AW-1:0] din_x;
  logic signed [AW-1:0] sum;
  logic                 over, under;
  logic signed [DW-1:0] clip;

  assign din_x = {{(AW-DW){bus.data_i[DW-1]}}, bus.data_i};
  assign sum   = acc_q + din_x;
  assign over  = sum > MAXV;
  assign under = sum < MINV;

  always_comb begin
    clip = sum[DW-1:0];
    if (over)
      clip = MAXV[DW-1:0];
    else if (under)
      clip = MINV[DW-1:0];
  end

  // clr wins over a same-cycle strobe; that sample is dropped
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    en_d   = 1'b0;
    sat_d  = 1'b0;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.data_i_en) begin
      if (cnt_q == LAST) begin
        dout_d = clip;
        en_d   = 1'b1;
        sat_d  = over | under;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      en_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      en_q   <= en_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.data_o_en = en_q;
  assign bus.data_o    = dout_q;
  assign bus.sat_o     = sat_q;

endmodule

// File: tb/tb_accumulate_dump.sv
// Directed bench for accumulate_dump with a result scoreboard.
// Also runs an acc_num=1 copy fed from the same samples.
module tb_accumulate_dump;

  localparam int H  = 5;
  localparam int W  = 20;
  localparam int N  = 4;
  localparam int DW = H + W;

  localparam longint MAXV = 16777215;
  localparam longint MINV = -16777216;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  accumulate_dump_if #(.DW(DW)) bus ();
  accumulate_dump_if #(.DW(DW)) bus1 ();

  assign bus1.data_i_en = bus.data_i_en;
  assign bus1.data_i    = bus.data_i;

  accumulate_dump #(
    .width_H (H),
    .width_W (W),
    .acc_num (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  accumulate_dump #(
    .width_H (H),
    .width_W (W),
    .acc_num (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus1.slave)
  );

  typedef struct {
    int     due;
    longint d;
    longint s;
  } exp_t;

  exp_t   q[$];
  int     cyc  = 0;
  int     ncmp = 0;
  int     nerr = 0;
  longint hold = 0;

  task automatic chk(string tag, longint got, longint want);
    ncmp++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check();
    logic   exp_now;
    exp_t   e;
    exp_now = (q.size() > 0) && (q[0].due == cyc);
    chk("data_o_en", longint'(bus.data_o_en), longint'(exp_now));
    if (exp_now && bus.data_o_en === 1'b1) begin
      e = q.pop_front();
      chk("data_o", longint'($signed(bus.data_o)), e.d);
      chk("sat_o", longint'(bus.sat_o), e.s);
      hold = e.d;
    end else begin
      if (exp_now)
        void'(q.pop_front());
      chk("sat_idle", longint'(bus.sat_o), 0);
      chk("data_hold", longint'($signed(bus.data_o)), hold);
    end
  endtask

  task automatic tick();
    logic   pv;
    longint pd;
    pv = bus.data_i_en && !clr && rst;
    pd = longint'($signed(bus.data_i));
    @(posedge clk);
    cyc++;
    #1;
    check();
    chk("n1_en", longint'(bus1.data_o_en), longint'(pv));
    if (pv)
      chk("n1_data", longint'($signed(bus1.data_o)), pd);
    chk("n1_sat", longint'(bus1.sat_o), 0);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic expect_out(longint d, longint s);
    exp_t e;
    e.due = cyc + 1;
    e.d   = d;
    e.s   = s;
    q.push_back(e);
  endtask

  task automatic sample(longint v);
    bus.data_i_en = 1'b1;
    bus.data_i    = DW'(v);
    tick();
    bus.data_i_en = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.data_i_en = 1'b0;
    bus.data_i    = '0;
    #2 rst = 1'b0;

    // random inputs held in reset
    for (int i = 0; i < 6; i++) begin
      bus.data_i_en = 1'($urandom_range(1));
      bus.data_i    = DW'($urandom);
      clr           = 1'($urandom_range(1));
      tick();
    end
    bus.data_i_en = 1'b0;
    clr           = 1'b0;
    rst           = 1'b1;
    idle(2);

    // 1..4 with gaps
    sample(1);
    idle(2);
    sample(2);
    sample(3);
    idle(3);
    expect_out(10, 0);
    sample(4);
    idle(2);

    // positive saturation
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        expect_out(MAXV, 1);
      sample(MAXV);
    end
    idle(1);

    // negative saturation
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        expect_out(MINV, 1);
      sample(MINV);
    end
    idle(2);

    // clr discards partial frame and same-cycle sample
    sample(7);
    sample(7);
    clr = 1'b1;
    sample(9);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        expect_out(20, 0);
      sample(5);
    end
    idle(3);

    // async reset mid-frame, between edges
    sample(1);
    sample(1);
    sample(1);
    #2 rst = 1'b0;
    #1;
    hold = 0;
    chk("rst_data_o", longint'($signed(bus.data_o)), 0);
    chk("rst_en", longint'(bus.data_o_en), 0);
    chk("rst_sat", longint'(bus.sat_o), 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        expect_out(4, 0);
      sample(1);
    end
    idle(2);

    // back-to-back across frame boundary
    bus.data_i_en = 1'b1;
    bus.data_i    = DW'(-3);
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7)
        expect_out(-12, 0);
      tick();
    end
    bus.data_i_en = 1'b0;
    idle(4);

    chk("queue_empty", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/accumulate_dump.md
ACCUMULATE_DUMP -- requirements
Module: accumulate_dump

Interface
REQ-001 Parameter width_H, default 5: integer bits of the signed fixed-point sample, sign bit included.
REQ-002 Parameter width_W, default 20: fractional bits of the sample.
REQ-003 Parameter acc_num, default 4: samples summed per output; legal range 1..1024.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 clr  input  1  synchronous frame clear, active-high.
REQ-007 data_i_en  input  1  sample valid strobe, one sample per high cycle.
REQ-008 data_i  input  width_H+width_W  signed two's-complement sample, from the power-of-two scaling stage.
REQ-009 data_o_en  output  1  result valid, single-cycle pulse.
REQ-010 data_o  output  width_H+width_W  saturated signed sum of one frame.
REQ-011 sat_o  output  1  high with data_o_en when data_o was clipped.

Function
REQ-012 Internal accumulator acc SHALL be signed, width_H+width_W+clog2(acc_num)+1 bits; each sample is sign-extended before it is added.
REQ-013 Internal counter cnt SHALL count accepted samples, 0..acc_num-1.
REQ-014 data_i_en high, clr low, cnt<acc_num-1: acc<=acc+data_i and cnt<=cnt+1; data_o_en<=0.
REQ-015 data_i_en high, clr low, cnt==acc_num-1: data_o<=sat(acc+data_i); data_o_en<=1; sat_o<=clip flag; acc<=0; cnt<=0.
REQ-016 Latency SHALL be 1 cycle from the clock edge that accepts the acc_num-th sample to data_o_en high.
REQ-017 data_i_en low: acc and cnt hold; data_o_en<=0 and sat_o<=0; data_o holds its last value.
REQ-018 Gaps of any length between strobes SHALL NOT affect the result.
REQ-019 Saturation: a sum above 2^(width_H+width_W-1)-1 SHALL give that maximum; a sum below -2^(width_H+width_W-1) SHALL give that minimum; in both cases sat_o=1. Otherwise data_o is the exact sum and sat_o=0.
REQ-020 clr high: acc<=0, cnt<=0, data_o_en<=0, sat_o<=0, and data_o holds.
REQ-021 clr has priority over data_i_en in the same cycle; that sample SHALL be discarded.
REQ-022 acc_num=1: every strobe SHALL produce a result 1 cycle later equal to data_i, with sat_o=0.
REQ-023 Back-to-back strobes across a frame boundary SHALL be accepted without stall; the first sample of the next frame is accepted on the cycle after the dump cycle.
REQ-024 No input backpressure exists; every strobe not blocked by clr or rst SHALL be accepted.

Reset
REQ-025 rst low SHALL immediately and asynchronously set acc=0, cnt=0, data_o_en=0, data_o=0 and sat_o=0.
REQ-026 rst low mid-frame SHALL discard the partial sum; after release, the next frame starts with cnt=0.
REQ-027 After release, the first edge with data_i_en high SHALL be accepted as sample 0.

Verification (width_H=5, width_W=20, acc_num=4; max=16777215, min=-16777216)
REQ-028 Drive rst low with random inputs -> data_o=0, data_o_en=0, sat_o=0 throughout.
REQ-029 Samples 1,2,3,4 with 0-3 idle cycles between them -> a single data_o_en pulse 1 cycle after the 4th sample; data_o=10; sat_o=0.
REQ-030 Four samples of 16777215 -> data_o=16777215, sat_o=1; then four samples of -16777216 -> data_o=-16777216, sat_o=1.
REQ-031 Samples 7,7, then clr together with a strobe of 9, then four samples of 5 -> exactly one pulse, data_o=20.
REQ-032 Three samples of 1, then rst pulsed low asynchronously between clock edges, then four samples of 1 -> data_o=4, with no pulse before that.
REQ-033 Eight back-to-back samples of -3 -> two pulses 4 cycles apart, each with data_o=-12 and sat_o=0.
